seg_scan_decoder: RTL
=====================

// Module: seg_scan_decoder
// PURPOSE
//  Reverse path of the BCD-to-7-segment encoder: monitors a multiplexed 7-segment display bus
//  (segment lines plus a one-hot digit strobe) and recovers the displayed BCD digits.
//  Each digit's pattern is debounced, decoded and assembled into a multi-digit frame.
//  Frames are delivered over a valid/ready handshake. Used for display loop-back checking.
// PARAMETERS
//  NDIG        4   number of scanned digits (1..8)
//  STABLE_CYC  3   consecutive identical cycles (seg + dig_sel) required before capture (1..255)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous, active-high reset
//  seg        in   [1:7]   segments a..g (bit 1 = a), active-high
//  dig_sel    in   NDIG    one-hot digit strobe; bit i selects digit i
//  bcd_out    out  4*NDIG  frame; digit i in bits [4i+3:4i]
//  out_err    out  NDIG    per-digit flag: pattern not a legal code
//  out_valid  out  1       frame available
//  out_ready  in   1       consumer accepts frame when out_valid & out_ready
//  overrun    out  1       sticky: completed frame dropped because output still pending
// BEHAVIOUR
//  - Reset: bcd_out=0, out_err=0, out_valid=0, overrun=0, capture mask=0, settle count=0, FSM=WAIT.
//  - Legal patterns (a..g):
//      0=1111110  1=0110000  2=1101101  3=1111001  4=0110011
//      5=1011011  6=1011111  7=1110000  8=1111111  9=1111011
//    Any other pattern decodes to 4'hE with the err bit set.
//  - dig_sel valid only when exactly one bit is set.
//    Zero or multi-hot dig_sel: FSM returns to WAIT and clears the count; the mask is unaffected.
//  - FSM:
//    * WAIT -> SETTLE on valid dig_sel; count=1; record seg/dig_sel.
//    * SETTLE: count increments while seg and dig_sel equal the recorded values.
//      Any change reloads the record with count=1 (stays SETTLE, or WAIT if dig_sel is invalid).
//      When count reaches STABLE_CYC, that same cycle captures the digit into the frame buffer,
//      sets the mask bit, and moves to HELD.
//    * HELD: no recapture until dig_sel changes. Changes to another valid digit -> SETTLE, count=1.
//      Invalid dig_sel -> WAIT.
//  - Recapturing an already-masked digit overwrites its value; the mask stays set.
//  - Frame complete when the mask is all ones (cycle T).
//    * Output register free (out_valid=0, or handshake in cycle T): load bcd_out/out_err and
//      assert out_valid at T+1; clear the mask at T+1.
//    * Output still pending: frame dropped, mask cleared, overrun set (sticky until rst).
//  - out_valid holds and bcd_out/out_err remain stable until the handshake.
//    The handshake cycle deasserts out_valid next cycle unless a new frame loads simultaneously.
//  - Minimum capture latency: STABLE_CYC cycles after strobe onset.
//  - Reset mid-capture discards any partial frame and any pending output.
// CONFIGURATION
//  SEG_BLANK_EN defined: all-zero pattern decodes to 4'hF (blank), err=0, and counts as captured.
//  Undefined: all-zero is illegal -> 4'hE, err=1.
// STRUCTURE
//  Package seg_scan_pkg:
//    - localparams for the ten segment patterns
//    - BCD_ERR=4'hE, BCD_BLANK=4'hF
//    - FSM state enum {WAIT, SETTLE, HELD}
//  Sub-module seg7_to_bcd: purely combinational; seg[1:7] -> {bcd[3:0], err}.
//    Honours SEG_BLANK_EN.
//  Top holds the FSM, settle counter, frame buffer/mask, and output register.
// TESTING
//  1. NDIG=4, STABLE_CYC=3: scan digits 0..3 with patterns for 1,2,3,4, each held 4 cycles,
//     out_ready=1 -> one out_valid pulse, bcd_out=16'h4321, out_err=0.
//  2. Digit 2 strobed for only 2 cycles, then digit 3 -> digit 2 not captured; no frame
//     until digit 2 is held >=3 cycles.
//  3. Digit 1 pattern 0000001 -> frame bcd_out[7:4]=4'hE, out_err=4'b0010.
//     All-zero on digit 0: with SEG_BLANK_EN -> 4'hF/err=0; without -> 4'hE/err=1.
//  4. out_ready=0 over two complete frames -> first frame held stable, second dropped,
//     overrun=1. Raise out_ready -> first frame accepted; overrun stays 1.
//  5. dig_sel=4'b0110 for 10 cycles -> no capture. Assert rst mid-frame (2 digits masked),
//     then scan 4 digits -> exactly one frame containing only post-reset values.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants and types for the 7-segment scan decoder.
// Segment patterns are written a..g, MSB first (index 1 = segment a).
package seg_scan_pkg;

    localparam logic [1:7] SEG_0 = 7'b1111110;
    localparam logic [1:7] SEG_1 = 7'b0110000;
    localparam logic [1:7] SEG_2 = 7'b1101101;
    localparam logic [1:7] SEG_3 = 7'b1111001;
    localparam logic [1:7] SEG_4 = 7'b0110011;
    localparam logic [1:7] SEG_5 = 7'b1011011;
    localparam logic [1:7] SEG_6 = 7'b1011111;
    localparam logic [1:7] SEG_7 = 7'b1110000;
    localparam logic [1:7] SEG_8 = 7'b1111111;
    localparam logic [1:7] SEG_9 = 7'b1111011;

    localparam logic [3:0] BCD_ERR   = 4'hE;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {WAIT, SETTLE, HELD} state_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD decoder.
// SEG_BLANK_EN: when defined, the all-dark pattern is a legal blank digit (4'hF).
module seg7_to_bcd
    import seg_scan_pkg::*;
(
    input  logic [1:7] seg,
    output logic [3:0] bcd,
    output logic       err
);

    // Map each legal pattern to its digit; anything else is flagged.
    always_comb begin
        bcd = BCD_ERR;
        err = 1'b1;
        case (seg)
            SEG_0: begin bcd = 4'd0; err = 1'b0; end
            SEG_1: begin bcd = 4'd1; err = 1'b0; end
            SEG_2: begin bcd = 4'd2; err = 1'b0; end
            SEG_3: begin bcd = 4'd3; err = 1'b0; end
            SEG_4: begin bcd = 4'd4; err = 1'b0; end
            SEG_5: begin bcd = 4'd5; err = 1'b0; end
            SEG_6: begin bcd = 4'd6; err = 1'b0; end
            SEG_7: begin bcd = 4'd7; err = 1'b0; end
            SEG_8: begin bcd = 4'd8; err = 1'b0; end
            SEG_9: begin bcd = 4'd9; err = 1'b0; end
`ifdef SEG_BLANK_EN
            7'b0000000: begin bcd = BCD_BLANK; err = 1'b0; end
`else
            7'b0000000: begin bcd = BCD_ERR; err = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment display bus.
// Each strobed digit must be stable for STABLE_CYC cycles before capture;
// a full set of captured digits is delivered as one frame over valid/ready.
// Optional build macro SEG_BLANK_EN (see seg7_to_bcd) accepts blank digits.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:7]          seg,
    input  logic [NDIG-1:0]     dig_sel,
    output logic [4*NDIG-1:0]   bcd_out,
    output logic [NDIG-1:0]     out_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
);

    state_t                 state;
    logic [7:0]             cnt;
    logic [1:7]             rec_seg;
    logic [NDIG-1:0]        rec_sel;
    logic [NDIG-1:0]        mask;
    logic [NDIG-1:0][3:0]   fbuf;
    logic [NDIG-1:0]        ebuf;

    logic                   sel_ok;
    logic                   same;
    logic                   eligible;
    logic [8:0]             nc;
    logic                   cap;
    logic [3:0]             dec_bcd;
    logic                   dec_err;

    seg7_to_bcd u_dec (
        .seg (seg),
        .bcd (dec_bcd),
        .err (dec_err)
    );

    // Settle bookkeeping: nc is the run length including this cycle;
    // capture fires on the cycle the run reaches STABLE_CYC.
    always_comb begin
        sel_ok   = $onehot(dig_sel);
        same     = (seg == rec_seg) && (dig_sel == rec_sel);
        // In HELD only a strobe change re-arms; segment flicker is ignored.
        eligible = sel_ok && !(state == HELD && dig_sel == rec_sel);
        nc       = (state == SETTLE && same) ? {1'b0, cnt} + 9'd1 : 9'd1;
        cap      = eligible && (nc == 9'(STABLE_CYC));
    end

    // Scan FSM: WAIT for a valid strobe, SETTLE while counting, HELD after capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT;
            cnt     <= 8'd0;
            rec_seg <= '0;
            rec_sel <= '0;
        end else if (!sel_ok) begin
            state <= WAIT;
            cnt   <= 8'd0;
        end else if (eligible) begin
            rec_seg <= seg;
            rec_sel <= dig_sel;
            cnt     <= nc[7:0];
            state   <= cap ? HELD : SETTLE;
        end
    end

    // Frame buffer, capture mask and output register with drop-on-busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask      <= '0;
            fbuf      <= '0;
            ebuf      <= '0;
            bcd_out   <= '0;
            out_err   <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (cap) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (dig_sel[i]) begin
                        fbuf[i] <= dec_bcd;
                        ebuf[i] <= dec_err;
                    end
                end
            end
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (&mask) begin
                // A capture in the completion cycle starts the next frame.
                mask <= cap ? dig_sel : '0;
                if (!out_valid || out_ready) begin
                    bcd_out   <= fbuf;
                    out_err   <= ebuf;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (cap) begin
                mask <= mask | dig_sel;
            end
        end
    end

endmodule
